// File: rtl/mips_cpu_pkg.sv
`default_nettype none
// ============================================================================
// mips_cpu_pkg : shared types and constants for the MIPS execute-stage units
// Revision     : 1.0 - initial divide controller support
// ============================================================================
package mips_cpu_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    CALC = 2'd1,
    FIX  = 2'd2,
    DONE = 2'd3
  } div_state_t;

  localparam int          DIV_STEPS  = 32;
  localparam logic [31:0] DIV_ZERO_Q = 32'hFFFF_FFFF;

endpackage
`default_nettype wire

// File: rtl/mips_cpu_div_step.sv
`default_nettype none
// ============================================================================
// mips_cpu_div_step : one combinational restoring shift-subtract iteration
// Revision          : 1.0 - initial
// ============================================================================
module mips_cpu_div_step #(
  parameter int WIDTH = 32
) (
  input  logic [WIDTH-1:0] rem,
  input  logic [WIDTH-1:0] q,
  input  logic [WIDTH-1:0] divisor,
  output logic [WIDTH-1:0] rem_nxt,
  output logic [WIDTH-1:0] q_nxt
);

  logic [WIDTH:0] w_shift;
  logic [WIDTH:0] w_diff;
  logic           w_fits;

  // The partial remainder is always below the divisor, so the shifted value
  // needs one extra bit and a borrow out of that bit means "does not fit".
  always_comb begin
    w_shift = {rem, q[WIDTH-1]};
    w_diff  = w_shift - {1'b0, divisor};
    w_fits  = ~w_diff[WIDTH];
    rem_nxt = w_fits ? w_diff[WIDTH-1:0] : w_shift[WIDTH-1:0];
    q_nxt   = {q[WIDTH-2:0], w_fits};
  end

endmodule
`default_nettype wire

// File: rtl/mips_cpu_div_ctrl.sv
`default_nettype none
// ============================================================================
// mips_cpu_div_ctrl : multi-cycle DIV/DIVU sequencer producing HI/LO results
// Revision          : 1.0 - initial
// ============================================================================
module mips_cpu_div_ctrl
  import mips_cpu_pkg::*;
#(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic             is_signed,
  input  logic             flush,
  input  logic [WIDTH-1:0] dividend,
  input  logic [WIDTH-1:0] divisor,
  output logic             busy,
  output logic             done,
  output logic             div_zero,
  output logic [WIDTH-1:0] hi,
  output logic [WIDTH-1:0] lo
);

  localparam int              c_cnt_w = $clog2(WIDTH) + 1;
  localparam logic [c_cnt_w-1:0] c_last_step = c_cnt_w'(DIV_STEPS - 1);

  div_state_t r_state;
  div_state_t w_state_nxt;
  logic       w_accept;

  logic [WIDTH-1:0]   r_rem;
  logic [WIDTH-1:0]   r_q;
  logic [WIDTH-1:0]   r_dvsr;
  logic [c_cnt_w-1:0] r_cnt;
  logic               r_neg_q;
  logic               r_neg_r;
  logic               r_dz;
  logic [WIDTH-1:0]   r_hi;
  logic [WIDTH-1:0]   r_lo;

  logic [WIDTH-1:0] w_abs_a;
  logic [WIDTH-1:0] w_abs_b;
  logic             w_dvsr_zero;
  logic [WIDTH-1:0] w_rem_nxt;
  logic [WIDTH-1:0] w_q_nxt;

  assign w_abs_a     = (is_signed && dividend[WIDTH-1]) ? -dividend : dividend;
  assign w_abs_b     = (is_signed && divisor[WIDTH-1])  ? -divisor  : divisor;
  assign w_dvsr_zero = (divisor == '0);

  mips_cpu_div_step #(
    .WIDTH (WIDTH)
  ) u_step (
    .rem     (r_rem),
    .q       (r_q),
    .divisor (r_dvsr),
    .rem_nxt (w_rem_nxt),
    .q_nxt   (w_q_nxt)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    w_accept    = 1'b0;
    case (r_state)
      IDLE: begin
        if (start && !flush) begin
          w_accept    = 1'b1;
          w_state_nxt = w_dvsr_zero ? DONE : CALC;
        end
      end
      CALC: begin
        if (flush) begin
          w_state_nxt = IDLE;
        end else if (r_cnt == c_last_step) begin
          w_state_nxt = FIX;
        end
      end
      FIX: begin
        w_state_nxt = flush ? IDLE : DONE;
      end
      DONE: begin
        w_state_nxt = IDLE;
      end
      default: begin
        w_state_nxt = IDLE;
      end
    endcase
  end

  // A zero divisor commits its fixed result at acceptance and skips the loop.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_rem   <= '0;
      r_q     <= '0;
      r_dvsr  <= '0;
      r_cnt   <= '0;
      r_neg_q <= 1'b0;
      r_neg_r <= 1'b0;
      r_dz    <= 1'b0;
      r_hi    <= '0;
      r_lo    <= '0;
    end else if (w_accept) begin
      r_rem   <= '0;
      r_cnt   <= '0;
      r_q     <= w_abs_a;
      r_dvsr  <= w_abs_b;
      r_neg_q <= is_signed & (dividend[WIDTH-1] ^ divisor[WIDTH-1]);
      r_neg_r <= is_signed & dividend[WIDTH-1];
      r_dz    <= w_dvsr_zero;
      if (w_dvsr_zero) begin
        r_lo <= WIDTH'(DIV_ZERO_Q);
        r_hi <= dividend;
      end
    end else if (r_state == CALC) begin
      r_rem <= w_rem_nxt;
      r_q   <= w_q_nxt;
      r_cnt <= r_cnt + c_cnt_w'(1);
    end else if (r_state == FIX && !flush) begin
      r_lo <= r_neg_q ? -r_q   : r_q;
      r_hi <= r_neg_r ? -r_rem : r_rem;
    end
  end

  assign busy     = (r_state != IDLE);
  assign done     = (r_state == DONE);
  assign div_zero = done & r_dz;
  assign hi       = r_hi;
  assign lo       = r_lo;

endmodule
`default_nettype wire

// File: tb/tb_mips_cpu_div_ctrl.sv
`default_nettype none
// ============================================================================
// tb_mips_cpu_div_ctrl : directed + random checks against an arithmetic model
// Revision             : 1.0 - initial
// ============================================================================
module tb_mips_cpu_div_ctrl;

  logic        clk       = 1'b0;
  logic        rst_n     = 1'b0;
  logic        start     = 1'b0;
  logic        is_signed = 1'b0;
  logic        flush     = 1'b0;
  logic [31:0] dividend  = '0;
  logic [31:0] divisor   = '0;
  logic        busy;
  logic        done;
  logic        div_zero;
  logic [31:0] hi;
  logic [31:0] lo;

  int          n_total = 0;
  int          n_bad   = 0;
  logic [31:0] m_hi    = '0;
  logic [31:0] m_lo    = '0;

  always #5 clk = ~clk;

  mips_cpu_div_ctrl #(
    .WIDTH (32)
  ) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .start     (start),
    .is_signed (is_signed),
    .flush     (flush),
    .dividend  (dividend),
    .divisor   (divisor),
    .busy      (busy),
    .done      (done),
    .div_zero  (div_zero),
    .hi        (hi),
    .lo        (lo)
  );

  task automatic check_val(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_total++;
    if (obs !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h", tag, obs, exp);
    end
  endtask

  // MIPS semantics: quotient truncates toward zero, remainder takes dividend sign.
  function automatic void ref_div(input logic [31:0] a, input logic [31:0] b, input logic sgn,
                                  output logic [31:0] q, output logic [31:0] r);
    longint sa, sb, lq, lr;
    if (b == 32'd0) begin
      q = 32'hFFFF_FFFF;
      r = a;
    end else if (sgn) begin
      sa = longint'($signed(a));
      sb = longint'($signed(b));
      lq = sa / sb;
      lr = sa % sb;
      q  = lq[31:0];
      r  = lr[31:0];
    end else begin
      q = a / b;
      r = a % b;
    end
  endfunction

  task automatic run_op(input logic [31:0] a, input logic [31:0] b, input logic sgn,
                        input int flush_at, input int restart_at);
    logic [31:0] eq, er;
    int          lat, seen, busy_cnt;
    bit          aborted;
    ref_div(a, b, sgn, eq, er);
    lat      = (b == 32'd0) ? 1 : 34;
    aborted  = (flush_at > 0) && (flush_at < lat);
    seen     = 0;
    busy_cnt = 0;
    @(negedge clk);
    dividend  = a;
    divisor   = b;
    is_signed = sgn;
    start     = 1'b1;
    for (int n = 1; n <= 60; n++) begin
      @(negedge clk);
      if (busy) busy_cnt++;
      if (done && seen == 0) seen = n;
      start = (n == restart_at);
      if (start) begin
        dividend  = $urandom;
        divisor   = $urandom;
        is_signed = 1'($urandom_range(0, 1));
      end
      flush = (n == flush_at);
      if (seen != 0) break;
      if (aborted && n == flush_at) break;
    end
    if (aborted) begin
      @(negedge clk);
      check_val("flush_idle", {31'b0, busy}, 32'd0);
      check_val("flush_no_done", 32'(seen) + {31'b0, done}, 32'd0);
      check_val("flush_hi_hold", hi, m_hi);
      check_val("flush_lo_hold", lo, m_lo);
      flush = 1'b0;
    end else begin
      check_val("latency", 32'(seen), 32'(lat));
      check_val("lo", lo, eq);
      check_val("hi", hi, er);
      check_val("div_zero", {31'b0, div_zero}, {31'b0, (b == 32'd0)});
      check_val("busy_cycles", 32'(busy_cnt), 32'(lat));
      @(negedge clk);
      check_val("done_pulse", {31'b0, done}, 32'd0);
      check_val("idle_after", {31'b0, busy}, 32'd0);
      flush = 1'b0;
      start = 1'b0;
      m_hi  = er;
      m_lo  = eq;
    end
  endtask

  initial begin
    logic [31:0] ra, rb;
    logic        rs;
    int          fa, sa;

    repeat (3) @(negedge clk);
    check_val("rst_busy", {31'b0, busy}, 32'd0);
    check_val("rst_done", {31'b0, done}, 32'd0);
    check_val("rst_dz", {31'b0, div_zero}, 32'd0);
    check_val("rst_hi", hi, 32'd0);
    check_val("rst_lo", lo, 32'd0);
    rst_n = 1'b1;

    run_op(32'd100, 32'd7, 1'b0, 0, 0);
    run_op(32'hFFFF_FF9C, 32'd7, 1'b1, 0, 0);
    run_op(32'd100, 32'hFFFF_FFF9, 1'b1, 0, 0);
    run_op(32'h8000_0000, 32'hFFFF_FFFF, 1'b1, 0, 0);
    run_op(32'hFFFF_FFFF, 32'd1, 1'b0, 0, 0);
    run_op(32'd5, 32'd0, 1'b0, 0, 0);
    run_op(32'hFFFF_FF00, 32'd0, 1'b1, 0, 0);
    run_op(32'd1000, 32'd3, 1'b0, 10, 0);
    repeat (2) @(negedge clk);
    run_op(32'd1000, 32'd3, 1'b0, 0, 0);
    run_op(32'd12345, 32'd67, 1'b0, 0, 5);
    run_op(32'hFFFF_F000, 32'd5, 1'b1, 33, 0);
    run_op(32'hFFFF_F000, 32'd5, 1'b1, 34, 0);

    for (int i = 0; i < 40; i++) begin
      ra = $urandom;
      case ($urandom_range(0, 7))
        0:       rb = 32'd0;
        1:       rb = 32'($urandom_range(1, 15));
        2:       rb = 32'hFFFF_FFFF;
        default: rb = $urandom;
      endcase
      if ($urandom_range(0, 3) == 0) ra = 32'($urandom_range(0, 1000));
      rs = 1'($urandom_range(0, 1));
      fa = ($urandom_range(0, 9) == 0) ? $urandom_range(1, 34) : 0;
      sa = (rb != 32'd0 && $urandom_range(0, 9) == 0) ? $urandom_range(1, 33) : 0;
      run_op(ra, rb, rs, fa, sa);
    end

    @(negedge clk);
    dividend  = 32'd999;
    divisor   = 32'd4;
    is_signed = 1'b0;
    start     = 1'b1;
    @(negedge clk);
    start = 1'b0;
    repeat (19) @(negedge clk);
    #1 rst_n = 1'b0;
    #1;
    check_val("arst_busy", {31'b0, busy}, 32'd0);
    check_val("arst_done", {31'b0, done}, 32'd0);
    check_val("arst_hi", hi, 32'd0);
    check_val("arst_lo", lo, 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    m_hi  = '0;
    m_lo  = '0;
    run_op(32'd81, 32'd9, 1'b0, 0, 0);

    $display("test done: total=%0d bad=%0d", n_total, n_bad);
    $finish;
  end

endmodule
`default_nettype wire
